// File: rtl/ysyx_22050710_memarb.sv
// Two-master (fetch / load-store) round-robin arbiter feeding one shared memory port.
// Exactly one memory transaction is outstanding; the response returns to its owner.
module ysyx_22050710_memarb #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  // instruction fetch (read-only)
  input  logic                    i_if_valid,
  output logic                    o_if_ready,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  // load / store
  input  logic                    i_ls_valid,
  output logic                    o_ls_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
  input  logic                    i_ls_wen,
  input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ls_wmask,
  output logic                    o_ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_ls_rdata,
  // shared memory port
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_wen,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wmask,
  input  logic                    i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_err
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  owner_e                  last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0]   wmask_q, wmask_d;
  logic                    mem_valid_q, mem_valid_d;
  logic                    err_q, err_d;

  logic                    grant_if;
  logic                    grant_ls;
  logic                    rsp_fire;

  // Round-robin grant: on a tie the requester that did not win last time goes first.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == S_IDLE) begin
      if (i_if_valid && i_ls_valid) begin
        grant_ls = (last_q == OWN_IF);
        grant_if = (last_q == OWN_LS);
      end else begin
        grant_if = i_if_valid;
        grant_ls = i_ls_valid;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    mem_valid_d = mem_valid_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_ls) begin
          addr_d      = i_ls_addr;
          wen_d       = i_ls_wen;
          wdata_d     = i_ls_wdata;
          wmask_d     = i_ls_wmask;
          owner_d     = OWN_LS;
          last_d      = OWN_LS;
          mem_valid_d = 1'b1;
          state_d     = S_REQ;
        end else if (grant_if) begin
          addr_d      = i_if_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '0;
          owner_d     = OWN_IF;
          last_d      = OWN_IF;
          mem_valid_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (i_mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_rsp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        mem_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // A response with nothing outstanding is a protocol error; it is never forwarded.
    if (i_mem_rsp_valid && (state_q != S_WAIT)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      mem_valid_q <= mem_valid_d;
      err_q       <= err_d;
    end
  end

  assign rsp_fire = (state_q == S_WAIT) && i_mem_rsp_valid;

  assign o_if_ready     = grant_if;
  assign o_ls_ready     = grant_ls;
  assign o_if_rsp_valid = rsp_fire && (owner_q == OWN_IF);
  assign o_ls_rsp_valid = rsp_fire && (owner_q == OWN_LS);
  assign o_if_rdata     = o_if_rsp_valid ? i_mem_rdata : '0;
  // Store acks carry no data.
  assign o_ls_rdata     = (o_ls_rsp_valid && !wen_q) ? i_mem_rdata : '0;

  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_ysyx_22050710_memarb.sv
// Randomized bench for the memory arbiter: a transaction-level round-robin model
// predicts grants, memory request fields and response routing.
module tb_ysyx_22050710_memarb;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid, if_ready, if_rsp_valid;
  logic [AW-1:0] if_addr_s;
  logic [DW-1:0] if_rdata;
  logic          ls_valid, ls_ready, ls_wen_s, ls_rsp_valid;
  logic [AW-1:0] ls_addr_s;
  logic [DW-1:0] ls_wdata_s, ls_rdata;
  logic [MW-1:0] ls_wmask_s;
  logic          mem_valid, mem_ready, mem_wen, mem_rsp_valid, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  always #5 clk = ~clk;

  ysyx_22050710_memarb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_valid(if_valid), .o_if_ready(if_ready), .i_if_addr(if_addr_s),
    .o_if_rsp_valid(if_rsp_valid), .o_if_rdata(if_rdata),
    .i_ls_valid(ls_valid), .o_ls_ready(ls_ready), .i_ls_addr(ls_addr_s),
    .i_ls_wen(ls_wen_s), .i_ls_wdata(ls_wdata_s), .i_ls_wmask(ls_wmask_s),
    .o_ls_rsp_valid(ls_rsp_valid), .o_ls_rdata(ls_rdata),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rdata(mem_rdata), .o_err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending request per master plus the last winner.
  bit            pend_if, pend_ls;
  bit            last_ls;
  logic [AW-1:0] m_if_addr, m_ls_addr;
  logic [DW-1:0] m_ls_wdata;
  logic [MW-1:0] m_ls_wmask;
  bit            m_ls_wen;
  int unsigned   grant_log[$];

  task automatic new_if();
    pend_if   = 1'b1;
    m_if_addr = {32'h8000_0000 | ($urandom & 32'h000f_fffc), 32'h0} >> 32;
  endtask

  task automatic new_ls();
    pend_ls    = 1'b1;
    m_ls_addr  = 64'h8000_0000 + 64'($urandom_range(0, 32'hffff) * 8);
    m_ls_wen   = 1'($urandom_range(0, 1));
    m_ls_wdata = {$urandom, $urandom};
    m_ls_wmask = 8'($urandom);
  endtask

  task automatic drive();
    if_valid   = pend_if;
    if_addr_s  = m_if_addr;
    ls_valid   = pend_ls;
    ls_addr_s  = m_ls_addr;
    ls_wen_s   = m_ls_wen;
    ls_wdata_s = m_ls_wdata;
    ls_wmask_s = m_ls_wmask;
  endtask

  task automatic chk_req(input bit g_ls, input logic [AW-1:0] e_addr, input bit e_wen,
                         input logic [DW-1:0] e_wdata, input logic [MW-1:0] e_wmask);
    chk("mem_valid", 64'(mem_valid), 64'd1);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wen", 64'(mem_wen), 64'(e_wen));
    chk("mem_wmask", 64'(mem_wmask), 64'(e_wmask));
    if (g_ls) chk("mem_wdata", mem_wdata, e_wdata);
    chk("busy_if_ready", 64'(if_ready), 64'd0);
    chk("busy_ls_ready", 64'(ls_ready), 64'd0);
  endtask

  // One full transaction starting at a negedge with the DUT idle.
  task automatic do_txn(input int bp, input int dly, input bit refill);
    bit            g_ls;
    logic [AW-1:0] e_addr;
    bit            e_wen;
    logic [DW-1:0] e_wdata, rd;
    logic [MW-1:0] e_wmask;
    drive();
    #1;
    g_ls = pend_ls && (!pend_if || !last_ls);
    chk("if_ready", 64'(if_ready), 64'(!g_ls));
    chk("ls_ready", 64'(ls_ready), 64'(g_ls));
    e_addr  = g_ls ? m_ls_addr : m_if_addr;
    e_wen   = g_ls ? m_ls_wen : 1'b0;
    e_wdata = m_ls_wdata;
    e_wmask = g_ls ? m_ls_wmask : '0;
    @(posedge clk);
    last_ls = g_ls;
    grant_log.push_back(g_ls ? 1 : 0);
    if (g_ls) pend_ls = 1'b0; else pend_if = 1'b0;
    if (refill || $urandom_range(0, 1) == 1) begin
      if (g_ls) new_ls(); else new_if();
    end
    @(negedge clk);
    drive();
    mem_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      #1 chk_req(g_ls, e_addr, e_wen, e_wdata, e_wmask);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1 chk_req(g_ls, e_addr, e_wen, e_wdata, e_wmask);
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < dly; i++) begin
      #1;
      chk("wait_mem_valid", 64'(mem_valid), 64'd0);
      chk("wait_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
      chk("wait_ready", 64'({if_ready, ls_ready}), 64'd0);
      @(negedge clk);
    end
    rd = {$urandom, $urandom};
    mem_rsp_valid = 1'b1;
    mem_rdata     = rd;
    #1;
    chk("if_rsp_valid", 64'(if_rsp_valid), 64'(!g_ls));
    chk("ls_rsp_valid", 64'(ls_rsp_valid), 64'(g_ls));
    chk("if_rdata", if_rdata, g_ls ? 64'd0 : rd);
    if (g_ls) chk("ls_rdata", ls_rdata, e_wen ? 64'd0 : rd);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pend_if = 1'b0; pend_ls = 1'b0; last_ls = 1'b0;
    m_if_addr = '0; m_ls_addr = '0; m_ls_wen = 1'b0; m_ls_wdata = '0; m_ls_wmask = '0;
    drive();
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'({if_ready, ls_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed fetch with the example address, then a store with the example fields.
    pend_if = 1'b1; m_if_addr = 64'h8000_0000;
    do_txn(0, 0, 1'b0);
    pend_if = 1'b0;
    pend_ls = 1'b1; m_ls_addr = 64'h8000_1000; m_ls_wen = 1'b1;
    m_ls_wdata = 64'hDEAD_BEEF; m_ls_wmask = 8'h0F;
    do_txn(5, 1, 1'b0);
    pend_ls = 1'b0;

    // Contention from a fresh reset must alternate LS, IF, LS, IF.
    rst = 1'b1; last_ls = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    new_if(); new_ls();
    for (int t = 0; t < 4; t++) do_txn(t, 0, 1'b1);
    for (int t = 0; t < 4; t++) chk("rr_order", 64'(grant_log[t]), (t % 2 == 0) ? 64'd1 : 64'd0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      if (!pend_if && !pend_ls) begin
        drive();
        #1 chk("idle_ready", 64'({if_ready, ls_ready}), 64'd0);
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) new_if();
        if ($urandom_range(0, 1) == 1) new_ls();
      end else begin
        do_txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
      end
    end
    chk("no_err_after_traffic", 64'(err), 64'd0);

    // Reset while waiting for the response; the late response must only raise err.
    while (pend_if || pend_ls) do_txn(0, 0, 1'b0);
    new_if();
    drive();
    @(posedge clk);
    @(negedge clk);
    pend_if = 1'b0; drive();
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstwait_mem_valid", 64'(mem_valid), 64'd0);
    chk("rstwait_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0; last_ls = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 64'h1234;
    #1 chk("late_rsp_pulse", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1 chk("late_rsp_err", 64'(err), 64'd1);

    // Spurious response in idle after a clean reset; err must stick.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("spur_pre_err", 64'(err), 64'd0);
    mem_rsp_valid = 1'b1;
    #1 chk("spur_pulse", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1 chk("spur_err", 64'(err), 64'd1);
    new_ls();
    do_txn(1, 1, 1'b0);
    repeat (3) @(negedge clk);
    #1 chk("spur_err_sticky", 64'(err), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
